// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: responder end of the split I/D memory handshake.
// It serves fetch (i_mem_*) and data (d_mem_*) requests over one shared pmem port,
// with one transaction in flight at a time. Each completion returns a one-cycle
// x_mem_resp pulse.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   i_mem_*          fetch request (held until i_mem_resp), resp pulse and read data
//   d_mem_*          data read/write request (held until d_mem_resp), resp pulse and read data
//   pmem_*           physical port; strobes are held until pmem_resp, fields are latched at grant
//   i_grant_count, d_grant_count, conflict_count
//                    saturating performance counters, present only when MEM_ARB_PERF_EN is defined
//
// Parameters:
//   FAIR       1: a fetch that waited behind a data transaction is granted next; 0: strict D priority
//   PERF_WIDTH performance counter width
module mem_request_arbiter #(
  parameter bit          FAIR       = 1'b1,
  parameter int unsigned PERF_WIDTH = 16,
  localparam int unsigned WORD_W    = 16,
  localparam int unsigned MASK_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_read,
  input  logic [WORD_W-1:0] i_mem_address,
  output logic              i_mem_resp,
  output logic [WORD_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [WORD_W-1:0] d_mem_address,
  input  logic [WORD_W-1:0] d_mem_wdata,
  input  logic [MASK_W-1:0] d_mem_byte_enable,
  output logic              d_mem_resp,
  output logic [WORD_W-1:0] d_mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [WORD_W-1:0] pmem_address,
  output logic [WORD_W-1:0] pmem_wdata,
  output logic [MASK_W-1:0] pmem_byte_enable,
  input  logic              pmem_resp,
  input  logic [WORD_W-1:0] pmem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] i_grant_count,
  output logic [PERF_WIDTH-1:0] d_grant_count,
  output logic [PERF_WIDTH-1:0] conflict_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE_I,
    ST_SERVE_D,
    ST_DONE_I,
    ST_DONE_D
  } state_t;

  state_t            state_q, state_d;
  logic              i_owed_q, i_owed_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_d, wdata_d, rdata_q, rdata_d;
  logic [MASK_W-1:0] mask_d;
  logic              pmem_read_d, pmem_write_d, i_resp_d, d_resp_d;
  logic              d_req;

  // Empty check block that keeps PERF_WIDTH referenced when the counters are compiled out.
  if (PERF_WIDTH == 0) begin : g_perf_width_zero
  end

  // Read and write together behave as a write.
  assign d_req = d_mem_read | d_mem_write;

  // Both resp ports present the single read-data latch; each is only meaningful during its pulse.
  assign i_mem_rdata = rdata_q;
  assign d_mem_rdata = rdata_q;

  // Next state, grant latching and next registered outputs.
  always_comb begin
    state_d  = state_q;
    i_owed_d = i_owed_q;
    we_d     = we_q;
    addr_d   = pmem_address;
    wdata_d  = pmem_wdata;
    mask_d   = pmem_byte_enable;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        // The i_mem_read term keeps a stale owed flag from starving D when no fetch is waiting.
        if (d_req && !(FAIR && i_owed_q && i_mem_read)) begin
          state_d = ST_SERVE_D;
          we_d    = d_mem_write;
          addr_d  = d_mem_address;
          wdata_d = d_mem_wdata;
          mask_d  = d_mem_write ? d_mem_byte_enable : {MASK_W{1'b1}};
          if (i_mem_read) i_owed_d = 1'b1;
        end else if (i_mem_read) begin
          state_d  = ST_SERVE_I;
          we_d     = 1'b0;
          addr_d   = i_mem_address;
          wdata_d  = '0;
          mask_d   = {MASK_W{1'b1}};
          i_owed_d = 1'b0;
        end
      end
      ST_SERVE_I: begin
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = ST_DONE_I;
        end
      end
      ST_SERVE_D: begin
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = ST_DONE_D;
        end
      end
      ST_DONE_I: state_d = ST_IDLE;
      ST_DONE_D: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    pmem_read_d  = (state_d == ST_SERVE_I) || ((state_d == ST_SERVE_D) && !we_d);
    pmem_write_d = (state_d == ST_SERVE_D) && we_d;
    i_resp_d     = (state_d == ST_DONE_I);
    d_resp_d     = (state_d == ST_DONE_D);
  end

  // State, latched transaction fields and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      i_owed_q         <= 1'b0;
      we_q             <= 1'b0;
      rdata_q          <= '0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      i_mem_resp       <= 1'b0;
      d_mem_resp       <= 1'b0;
    end else begin
      state_q          <= state_d;
      i_owed_q         <= i_owed_d;
      we_q             <= we_d;
      rdata_q          <= rdata_d;
      pmem_address     <= addr_d;
      pmem_wdata       <= wdata_d;
      pmem_byte_enable <= mask_d;
      pmem_read        <= pmem_read_d;
      pmem_write       <= pmem_write_d;
      i_mem_resp       <= i_resp_d;
      d_mem_resp       <= d_resp_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic i_grant_evt, d_grant_evt, conflict_evt;

  assign i_grant_evt  = (state_q == ST_IDLE) && (state_d == ST_SERVE_I);
  assign d_grant_evt  = (state_q == ST_IDLE) && (state_d == ST_SERVE_D);
  // A request counts as waiting in any cycle its own port is neither serving nor responding.
  assign conflict_evt = (i_mem_read && !((state_q == ST_SERVE_I) || (state_q == ST_DONE_I))) ||
                        (d_req && !((state_q == ST_SERVE_D) || (state_q == ST_DONE_D)));

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_grant_count  <= '0;
      d_grant_count  <= '0;
      conflict_count <= '0;
    end else begin
      if (i_grant_evt && (i_grant_count != '1))
        i_grant_count <= i_grant_count + PERF_WIDTH'(1);
      if (d_grant_evt && (d_grant_count != '1))
        d_grant_count <= d_grant_count + PERF_WIDTH'(1);
      if (conflict_evt && (conflict_count != '1))
        conflict_count <= conflict_count + PERF_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter: instance 0 has FAIR=1 and instance 1 has FAIR=0.
// A timed pmem responder with configurable latency serves both instances. Results are
// checked against a reference memory model and against the grant-order rules.
module tb_mem_request_arbiter;

  localparam int unsigned PW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [1:0]           i_mem_read, d_mem_read, d_mem_write, pmem_resp;
  logic [1:0][15:0]     i_mem_address, d_mem_address, d_mem_wdata, pmem_rdata;
  logic [1:0][1:0]      d_mem_byte_enable;
  wire  [1:0]           i_mem_resp, d_mem_resp, pmem_read, pmem_write;
  wire  [1:0][15:0]     i_mem_rdata, d_mem_rdata, pmem_address, pmem_wdata;
  wire  [1:0][1:0]      pmem_byte_enable;
`ifdef MEM_ARB_PERF_EN
  wire  [1:0][PW-1:0]   i_gc, d_gc, cf_c;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_request_arbiter #(.FAIR(g == 0), .PERF_WIDTH(PW)) u_dut (
      .clk               (clk),
      .reset             (reset),
      .i_mem_read        (i_mem_read[g]),
      .i_mem_address     (i_mem_address[g]),
      .i_mem_resp        (i_mem_resp[g]),
      .i_mem_rdata       (i_mem_rdata[g]),
      .d_mem_read        (d_mem_read[g]),
      .d_mem_write       (d_mem_write[g]),
      .d_mem_address     (d_mem_address[g]),
      .d_mem_wdata       (d_mem_wdata[g]),
      .d_mem_byte_enable (d_mem_byte_enable[g]),
      .d_mem_resp        (d_mem_resp[g]),
      .d_mem_rdata       (d_mem_rdata[g]),
      .pmem_read         (pmem_read[g]),
      .pmem_write        (pmem_write[g]),
      .pmem_address      (pmem_address[g]),
      .pmem_wdata        (pmem_wdata[g]),
      .pmem_byte_enable  (pmem_byte_enable[g]),
      .pmem_resp         (pmem_resp[g]),
      .pmem_rdata        (pmem_rdata[g])
`ifdef MEM_ARB_PERF_EN
      ,
      .i_grant_count     (i_gc[g]),
      .d_grant_count     (d_gc[g]),
      .conflict_count    (cf_c[g])
`endif
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int lat_cfg [2];
  logic [1:0] force_resp;
  logic [15:0] ref_mem [2][256];

  function automatic logic [15:0] seed_val(input int g, input int i);
    return 16'hBEEF ^ 16'(i * 37) ^ 16'(g * 16'h1111);
  endfunction

  // pmem model: answers lat_cfg cycles after the strobe first appears (0 = same cycle).
  logic [15:0] pm [2][256];
  bit pm_ready;
  int resp_cnt [2];
  always @(posedge clk) begin
    #2;
    if (!pm_ready) begin
      for (int g = 0; g < 2; g++)
        for (int i = 0; i < 256; i++) pm[g][i] = seed_val(g, i);
      pm_ready = 1'b1;
    end
    for (int g = 0; g < 2; g++) begin
      if ((pmem_read[g] || pmem_write[g]) && resp_cnt[g] == lat_cfg[g]) begin
        if (pmem_write[g]) begin
          if (pmem_byte_enable[g][0]) pm[g][pmem_address[g][7:0]][7:0]  = pmem_wdata[g][7:0];
          if (pmem_byte_enable[g][1]) pm[g][pmem_address[g][7:0]][15:8] = pmem_wdata[g][15:8];
          pmem_rdata[g] = 16'($urandom);
        end else begin
          pmem_rdata[g] = pm[g][pmem_address[g][7:0]];
        end
        pmem_resp[g] = 1'b1;
        resp_cnt[g]  = 0;
      end else begin
        pmem_resp[g]  = force_resp[g];
        pmem_rdata[g] = 16'($urandom);
        if (pmem_read[g] || pmem_write[g]) resp_cnt[g]++;
        else resp_cnt[g] = 0;
      end
    end
  end

  task automatic clear_inputs();
    i_mem_read = '0; d_mem_read = '0; d_mem_write = '0;
    i_mem_address = '0; d_mem_address = '0; d_mem_wdata = '0; d_mem_byte_enable = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated transaction on instance sel, checked against the reference memory and latency rule.
  task automatic do_txn(input int sel, input bit is_d, input bit rd, input bit wr,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, input int lat);
    bit exp_wr;
    logic [1:0] exp_be;
    logic [15:0] got;
    int resp_at;
    bit other;
    exp_wr  = is_d && wr;
    exp_be  = exp_wr ? be : 2'b11;
    resp_at = 0;
    other   = 1'b0;
    lat_cfg[sel] = lat;
    @(negedge clk);
    if (is_d) begin
      d_mem_read[sel] = rd; d_mem_write[sel] = wr; d_mem_address[sel] = addr;
      d_mem_wdata[sel] = wdata; d_mem_byte_enable[sel] = be;
    end else begin
      i_mem_read[sel] = 1'b1; i_mem_address[sel] = addr;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if ({pmem_read[sel], pmem_write[sel]} !== {~exp_wr, exp_wr}) begin
          n_bad++;
          $display("FAIL txn_strobe[%0d]: got rd/wr %b expected %b", sel,
                   {pmem_read[sel], pmem_write[sel]}, {~exp_wr, exp_wr});
        end
        n_cmp++;
        if (pmem_address[sel] !== addr || pmem_byte_enable[sel] !== exp_be) begin
          n_bad++;
          $display("FAIL txn_addr_mask[%0d]: got %h/%b expected %h/%b", sel,
                   pmem_address[sel], pmem_byte_enable[sel], addr, exp_be);
        end
        if (exp_wr) begin
          n_cmp++;
          if (pmem_wdata[sel] !== wdata) begin
            n_bad++;
            $display("FAIL txn_wdata[%0d]: got %h expected %h", sel, pmem_wdata[sel], wdata);
          end
        end
      end
      if ((is_d ? i_mem_resp[sel] : d_mem_resp[sel]) === 1'b1) other = 1'b1;
      if ((is_d ? d_mem_resp[sel] : i_mem_resp[sel]) === 1'b1) begin
        resp_at = c;
        if (!exp_wr) begin
          got = is_d ? d_mem_rdata[sel] : i_mem_rdata[sel];
          n_cmp++;
          if (got !== ref_mem[sel][addr[7:0]]) begin
            n_bad++;
            $display("FAIL txn_rdata[%0d] addr %h: got %h expected %h", sel, addr, got,
                     ref_mem[sel][addr[7:0]]);
          end
        end
        break;
      end
    end
    i_mem_read[sel] = 1'b0; d_mem_read[sel] = 1'b0; d_mem_write[sel] = 1'b0;
    if (exp_wr) begin
      if (be[0]) ref_mem[sel][addr[7:0]][7:0]  = wdata[7:0];
      if (be[1]) ref_mem[sel][addr[7:0]][15:8] = wdata[15:8];
    end
    n_cmp++;
    if (resp_at != lat + 2) begin
      n_bad++;
      $display("FAIL txn_latency[%0d]: got resp at cycle %0d (0=none) expected %0d", sel, resp_at, lat + 2);
    end
    @(negedge clk);
    n_cmp++;
    if (i_mem_resp[sel] !== 1'b0 || d_mem_resp[sel] !== 1'b0 || other) begin
      n_bad++;
      $display("FAIL txn_extra_resp[%0d]: got i=%b d=%b wrong_port=%b expected none", sel,
               i_mem_resp[sel], d_mem_resp[sel], other);
    end
  endtask

  // Simultaneous I read 0x2000 and D write 0x3000; D optionally issues follow-up reads right after each resp.
  task automatic run_pair(input int sel, input int lat, input int reissue, output string order);
    int d_left;
    lat_cfg[sel] = lat;
    order  = "";
    d_left = reissue;
    @(negedge clk);
    i_mem_read[sel] = 1'b1; i_mem_address[sel] = 16'h2000;
    d_mem_write[sel] = 1'b1; d_mem_read[sel] = 1'b0; d_mem_address[sel] = 16'h3000;
    d_mem_wdata[sel] = 16'h1234; d_mem_byte_enable[sel] = 2'b01;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if ({pmem_read[sel], pmem_write[sel], pmem_byte_enable[sel], pmem_address[sel], pmem_wdata[sel]}
            !== {1'b0, 1'b1, 2'b01, 16'h3000, 16'h1234}) begin
          n_bad++;
          $display("FAIL pair_first_grant[%0d]: got rd=%b wr=%b be=%b addr=%h wd=%h expected D write 01/3000/1234",
                   sel, pmem_read[sel], pmem_write[sel], pmem_byte_enable[sel], pmem_address[sel], pmem_wdata[sel]);
        end
      end
      if (d_mem_resp[sel] === 1'b1) begin
        order = {order, "D"};
        if (d_mem_write[sel]) ref_mem[sel][8'h00][7:0] = 8'h34;
        if (d_left > 0) begin
          d_left--;
          d_mem_write[sel] = 1'b0; d_mem_read[sel] = 1'b1; d_mem_address[sel] = 16'h3100;
        end else begin
          d_mem_write[sel] = 1'b0; d_mem_read[sel] = 1'b0;
        end
      end
      if (i_mem_resp[sel] === 1'b1) begin
        order = {order, "I"};
        i_mem_read[sel] = 1'b0;
      end
      if (!i_mem_read[sel] && !d_mem_read[sel] && !d_mem_write[sel]) break;
    end
    if (i_mem_read[sel] || d_mem_read[sel] || d_mem_write[sel]) begin
      n_cmp++; n_bad++;
      $display("FAIL pair_timeout[%0d]: got order %s with requests still pending expected all served", sel, order);
      i_mem_read[sel] = 1'b0; d_mem_read[sel] = 1'b0; d_mem_write[sel] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({pmem_read[s], pmem_write[s], i_mem_resp[s], d_mem_resp[s]} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 0000", s,
                 {pmem_read[s], pmem_write[s], i_mem_resp[s], d_mem_resp[s]});
      end
      n_cmp++;
      if ({pmem_address[s], pmem_wdata[s], pmem_byte_enable[s], i_mem_rdata[s], d_mem_rdata[s]} !== '0) begin
        n_bad++;
        $display("FAIL reset_data[%0d]: got addr=%h wd=%h be=%b ird=%h drd=%h expected all 0", s,
                 pmem_address[s], pmem_wdata[s], pmem_byte_enable[s], i_mem_rdata[s], d_mem_rdata[s]);
      end
`ifdef MEM_ARB_PERF_EN
      n_cmp++;
      if ({i_gc[s], d_gc[s], cf_c[s]} !== '0) begin
        n_bad++;
        $display("FAIL reset_perf[%0d]: got %0d/%0d/%0d expected 0/0/0", s, i_gc[s], d_gc[s], cf_c[s]);
      end
`endif
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch_min_latency();
    for (int s = 0; s < 2; s++) do_txn(s, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0, 2'b00, 0);
  endtask

  task automatic test_read_write_both();
    for (int s = 0; s < 2; s++) begin
      do_txn(s, 1'b1, 1'b1, 1'b1, 16'h5055, 16'hA5A5, 2'b11, 2);
      do_txn(s, 1'b1, 1'b1, 1'b0, 16'h5055, 16'h0, 2'b00, 1);
      do_txn(s, 1'b0, 1'b0, 1'b0, 16'h5055, 16'h0, 2'b00, 0);
    end
  endtask

  task automatic test_long_latency();
    int resp_cycles, first_resp, addr_bad;
    resp_cycles = 0; first_resp = 0; addr_bad = 0;
    lat_cfg[0] = 5;
    @(negedge clk);
    d_mem_read[0] = 1'b1; d_mem_address[0] = 16'h4000;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) d_mem_address[0] = 16'h4444;
      if ((pmem_read[0] || pmem_write[0]) && pmem_address[0] !== 16'h4000) addr_bad++;
      if (d_mem_resp[0] === 1'b1) begin
        resp_cycles++;
        if (first_resp == 0) begin
          first_resp = c;
          n_cmp++;
          if (d_mem_rdata[0] !== ref_mem[0][8'h00]) begin
            n_bad++;
            $display("FAIL long_rdata: got %h expected %h", d_mem_rdata[0], ref_mem[0][8'h00]);
          end
        end
        d_mem_read[0] = 1'b0;
      end
    end
    n_cmp++;
    if (addr_bad != 0) begin
      n_bad++;
      $display("FAIL long_addr_stable: got %0d cycles with address != 4000 expected 0", addr_bad);
    end
    n_cmp++;
    if (resp_cycles != 1 || first_resp != 7) begin
      n_bad++;
      $display("FAIL long_resp: got %0d resp cycles first at %0d expected 1 at 7", resp_cycles, first_resp);
    end
  endtask

  task automatic test_fairness();
    string order, exp;
    for (int s = 0; s < 2; s++) begin
      run_pair(s, 1, 1, order);
      exp = (s == 0) ? "DID" : "DDI";
      n_cmp++;
      if (order != exp) begin
        n_bad++;
        $display("FAIL fair_order[%0d]: got %s expected %s", s, order, exp);
      end
    end
  endtask

  task automatic test_reset_mid_serve();
    int bad;
    bad = 0;
    lat_cfg[0] = 1000;
    @(negedge clk);
    i_mem_read[0] = 1'b1; i_mem_address[0] = 16'h6000;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (pmem_read[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_serve_strobe: got pmem_read=%b expected 1", pmem_read[0]);
    end
    reset = 1'b1;
    i_mem_read[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pmem_read[0] !== 1'b0 || i_mem_resp[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_serve_reset: got pmem_read=%b i_mem_resp=%b expected 0/0", pmem_read[0], i_mem_resp[0]);
    end
    reset = 1'b0;
    force_resp[0] = 1'b1;
    @(negedge clk);
    force_resp[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (i_mem_resp[0] !== 1'b0 || d_mem_resp[0] !== 1'b0 || pmem_read[0] !== 1'b0 || pmem_write[0] !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL stale_resp: got %0d cycles with resp/strobe activity expected 0", bad);
    end
    do_txn(0, 1'b0, 1'b0, 1'b0, 16'h6000, 16'h0, 2'b00, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int s;
      bit is_d, rd, wr;
      s    = int'($urandom_range(1, 0));
      is_d = 1'($urandom);
      rd   = 1'($urandom);
      wr   = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      do_txn(s, is_d, rd, wr, 16'($urandom), 16'($urandom), 2'($urandom), int'($urandom_range(4, 0)));
    end
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    string order;
    apply_reset();
    for (int s = 0; s < 2; s++) begin
      run_pair(s, 3, 0, order);
      do_txn(s, 1'b0, 1'b0, 1'b0, 16'h7000, 16'h0, 2'b00, 0);
      do_txn(s, 1'b0, 1'b0, 1'b0, 16'h7001, 16'h0, 2'b00, 1);
      do_txn(s, 1'b1, 1'b1, 1'b0, 16'h7002, 16'h0, 2'b00, 0);
      n_cmp++;
      if (i_gc[s] !== PW'(3) || d_gc[s] !== PW'(2) || cf_c[s] < PW'(4)) begin
        n_bad++;
        $display("FAIL perf_counts[%0d]: got %0d/%0d/%0d expected 3/2/>=4", s, i_gc[s], d_gc[s], cf_c[s]);
      end
      for (int n = 0; n < 14; n++) do_txn(s, 1'b0, 1'b0, 1'b0, 16'h7100, 16'h0, 2'b00, 0);
      n_cmp++;
      if (i_gc[s] !== '1 || d_gc[s] !== PW'(2) || cf_c[s] !== '1) begin
        n_bad++;
        $display("FAIL perf_saturate[%0d]: got %0d/%0d/%0d expected 15/2/15", s, i_gc[s], d_gc[s], cf_c[s]);
      end
    end
  endtask
`endif

  initial begin
    force_resp = '0;
    lat_cfg[0] = 0;
    lat_cfg[1] = 0;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 256; i++) ref_mem[g][i] = seed_val(g, i);
    test_reset();
    test_fetch_min_latency();
    test_read_write_both();
    test_long_latency();
    test_fairness();
    test_reset_mid_serve();
    test_random();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
